kugelblitz_rx_frame_check: RTL and testbench



---
 rtl/kugelblitz_rx_frame_check_pkg.sv | 26 ++
 rtl/kugelblitz_keep_count.sv | 20 ++
 rtl/kugelblitz_rx_frame_check.sv | 190 +++++++++++++++++++
 tb/tb_kugelblitz_rx_frame_check.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kugelblitz_rx_frame_check_pkg.sv
// Shared types and constants for the kugelblitz RX frame checker and its helpers.
// State encodings, counter widths and the tuser error bit position live here.
package kugelblitz_rx_frame_check_pkg;

    typedef enum logic [1:0] {
        KB_RX_IDLE = 2'd0,
        KB_RX_PASS = 2'd1,
        KB_RX_DROP = 2'd2
    } kb_rx_state_e;

    localparam int KB_CNT_WIDTH      = 16;
    localparam int KB_STAT_WIDTH     = 32;
    localparam int KB_TUSER_ERR      = 0;
    localparam int KB_KEEP_CNT_WIDTH = 7;

    // Saturating frame byte counter update.
    function automatic logic [KB_CNT_WIDTH-1:0] kb_sat_add(
        input logic [KB_CNT_WIDTH-1:0]      a,
        input logic [KB_KEEP_CNT_WIDTH-1:0] b
    );
        logic [KB_CNT_WIDTH:0] s;
        s = {1'b0, a} + {{(KB_CNT_WIDTH-KB_KEEP_CNT_WIDTH+1){1'b0}}, b};
        return s[KB_CNT_WIDTH] ? {KB_CNT_WIDTH{1'b1}} : s[KB_CNT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/kugelblitz_keep_count.sv
// Purpose: popcount of a tkeep vector (number of valid bytes in a beat).
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake involved.
module kugelblitz_keep_count
    import kugelblitz_rx_frame_check_pkg::*;
#(
    parameter int KEEP_WIDTH = 64
) (
    input  logic [KEEP_WIDTH-1:0]        keep,
    output logic [KB_KEEP_CNT_WIDTH-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            count = count + KB_KEEP_CNT_WIDTH'(keep[i]);
        end
    end

endmodule

// File: rtl/kugelblitz_rx_frame_check.sv
// Purpose: RX frame check - zero unused bytes, drop runts, truncate oversize, flag FCS errors.
// Latency: one cycle, single registered output stage, full throughput.
// Backpressure: s_axis_tready = !m_axis_tvalid || m_axis_tready; stats via KUGELBLITZ_RX_STATS_EN.
module kugelblitz_rx_frame_check
    import kugelblitz_rx_frame_check_pkg::*;
#(
    parameter int DATA_WIDTH    = 512,
    parameter int KEEP_WIDTH    = 64,
    parameter int USER_WIDTH    = 1,
    parameter int MIN_FRAME_LEN = 60,
    parameter int MAX_FRAME_LEN = 9600
) (
    input  logic                     qsfp_rx_clk,
    input  logic                     qsfp_rx_rst_n,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic [USER_WIDTH-1:0]    s_axis_tuser,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [USER_WIDTH-1:0]    m_axis_tuser,
    output logic [KB_STAT_WIDTH-1:0] stat_rx_frames,
    output logic [KB_STAT_WIDTH-1:0] stat_rx_runt,
    output logic [KB_STAT_WIDTH-1:0] stat_rx_oversize,
    output logic [KB_STAT_WIDTH-1:0] stat_rx_fcs_err
);

    if (DATA_WIDTH != 512 || KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_bad_width
        $error("kugelblitz_rx_frame_check: only DATA_WIDTH=512 with KEEP_WIDTH=64 is supported");
    end
    if (MIN_FRAME_LEN < 1 || MIN_FRAME_LEN > KEEP_WIDTH) begin : g_bad_min
        $error("kugelblitz_rx_frame_check: MIN_FRAME_LEN out of range");
    end
    if (MAX_FRAME_LEN < MIN_FRAME_LEN || MAX_FRAME_LEN > 65534) begin : g_bad_max
        $error("kugelblitz_rx_frame_check: MAX_FRAME_LEN out of range");
    end

    localparam logic [KB_CNT_WIDTH-1:0] MIN_LEN = KB_CNT_WIDTH'(MIN_FRAME_LEN);
    localparam logic [KB_CNT_WIDTH-1:0] MAX_LEN = KB_CNT_WIDTH'(MAX_FRAME_LEN);

    kb_rx_state_e                 state_q, state_d;
    logic [KB_CNT_WIDTH-1:0]      cnt_q;
    logic [KB_CNT_WIDTH-1:0]      run_cnt;
    logic [KB_KEEP_CNT_WIDTH-1:0] beat_bytes;
    logic                         accept;
    logic                         is_runt;
    logic                         is_over;
    logic                         fwd, fwd_last, fwd_err;
    logic                         runt_inc, over_inc, fcs_inc, frame_inc;
    logic [USER_WIDTH-1:0]        user_d;
    logic [DATA_WIDTH-1:0]        data_masked;

    kugelblitz_keep_count #(
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_keep_count (
        .keep  (s_axis_tkeep),
        .count (beat_bytes)
    );

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign run_cnt       = kb_sat_add(cnt_q, beat_bytes);
    assign is_runt       = s_axis_tlast &&
                           ({{(KB_CNT_WIDTH-KB_KEEP_CNT_WIDTH){1'b0}}, beat_bytes} < MIN_LEN);
    assign is_over       = run_cnt > MAX_LEN;

    always_comb begin
        data_masked = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            data_masked[i*8 +: 8] = s_axis_tdata[i*8 +: 8] & {8{s_axis_tkeep[i]}};
        end
    end

    always_comb begin
        state_d   = state_q;
        fwd       = 1'b0;
        fwd_last  = 1'b0;
        fwd_err   = 1'b0;
        runt_inc  = 1'b0;
        over_inc  = 1'b0;
        fcs_inc   = 1'b0;
        frame_inc = 1'b0;
        if (accept) begin
            case (state_q)
                KB_RX_IDLE, KB_RX_PASS: begin
                    if (state_q == KB_RX_IDLE && is_runt) begin
                        runt_inc = 1'b1;
                    end else if (is_over) begin
                        // Truncate here; oversize wins over any FCS flag on this beat.
                        fwd       = 1'b1;
                        fwd_last  = 1'b1;
                        fwd_err   = 1'b1;
                        over_inc  = 1'b1;
                        frame_inc = 1'b1;
                        state_d   = s_axis_tlast ? KB_RX_IDLE : KB_RX_DROP;
                    end else begin
                        fwd      = 1'b1;
                        fwd_last = s_axis_tlast;
                        if (s_axis_tlast) begin
                            frame_inc = 1'b1;
                            fcs_inc   = s_axis_tuser[KB_TUSER_ERR];
                            state_d   = KB_RX_IDLE;
                        end else begin
                            state_d = KB_RX_PASS;
                        end
                    end
                end
                KB_RX_DROP: begin
                    if (s_axis_tlast) begin
                        state_d = KB_RX_IDLE;
                    end
                end
                default: state_d = KB_RX_IDLE;
            endcase
        end
    end

    always_comb begin
        user_d = s_axis_tuser;
        if (fwd_err) begin
            user_d[KB_TUSER_ERR] = 1'b1;
        end
    end

    always_ff @(posedge qsfp_rx_clk or negedge qsfp_rx_rst_n) begin
        if (!qsfp_rx_rst_n) begin
            state_q <= KB_RX_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= s_axis_tlast ? '0 : run_cnt;
            end
        end
    end

    always_ff @(posedge qsfp_rx_clk or negedge qsfp_rx_rst_n) begin
        if (!qsfp_rx_rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (s_axis_tready) begin
            m_axis_tvalid <= fwd;
            if (fwd) begin
                m_axis_tdata <= data_masked;
                m_axis_tkeep <= s_axis_tkeep;
                m_axis_tlast <= fwd_last;
                m_axis_tuser <= user_d;
            end
        end
    end

`ifdef KUGELBLITZ_RX_STATS_EN
    logic [KB_STAT_WIDTH-1:0] frames_q, runt_q, over_q, fcs_q;

    always_ff @(posedge qsfp_rx_clk or negedge qsfp_rx_rst_n) begin
        if (!qsfp_rx_rst_n) begin
            frames_q <= '0;
            runt_q   <= '0;
            over_q   <= '0;
            fcs_q    <= '0;
        end else begin
            if (frame_inc) frames_q <= frames_q + 32'd1;
            if (runt_inc)  runt_q   <= runt_q + 32'd1;
            if (over_inc)  over_q   <= over_q + 32'd1;
            if (fcs_inc)   fcs_q    <= fcs_q + 32'd1;
        end
    end

    assign stat_rx_frames   = frames_q;
    assign stat_rx_runt     = runt_q;
    assign stat_rx_oversize = over_q;
    assign stat_rx_fcs_err  = fcs_q;
`else
    logic stats_unused;
    assign stats_unused     = ^{frame_inc, runt_inc, over_inc, fcs_inc};
    assign stat_rx_frames   = '0;
    assign stat_rx_runt     = '0;
    assign stat_rx_oversize = '0;
    assign stat_rx_fcs_err  = '0;
`endif

endmodule

// File: tb/tb_kugelblitz_rx_frame_check.sv
// Bench for kugelblitz_rx_frame_check: two instances (default and MAX_FRAME_LEN=128)
// driven by directed and random frames, checked against a frame-level reference model.
module tb_kugelblitz_rx_frame_check;

`ifdef KUGELBLITZ_RX_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif
    localparam int MIN_LEN = 60;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        logic         u;
    } beat_t;

    logic         clk;
    logic         rst_n;
    logic [511:0] s_tdata  [2];
    logic [63:0]  s_tkeep  [2];
    logic         s_tvalid [2];
    logic         s_tready [2];
    logic         s_tlast  [2];
    logic [0:0]   s_tuser  [2];
    logic [511:0] m_tdata  [2];
    logic [63:0]  m_tkeep  [2];
    logic         m_vld    [2];
    logic         m_rdy    [2];
    logic         m_tlast  [2];
    logic [0:0]   m_tuser  [2];
    logic [31:0]  st_frames[2];
    logic [31:0]  st_runt  [2];
    logic [31:0]  st_over  [2];
    logic [31:0]  st_fcs   [2];

    int    tests = 0;
    int    fails = 0;
    int    m_frames[2];
    int    m_runt[2];
    int    m_over[2];
    int    m_fcs[2];
    int    rdy_mode;
    beat_t q0[$];
    beat_t q1[$];
    beat_t e_tmp;
    logic         hold_v[2];
    logic [511:0] hold_d[2];
    logic [65:0]  hold_c[2];

    kugelblitz_rx_frame_check dut0 (
        .qsfp_rx_clk(clk), .qsfp_rx_rst_n(rst_n),
        .s_axis_tdata(s_tdata[0]), .s_axis_tkeep(s_tkeep[0]), .s_axis_tvalid(s_tvalid[0]),
        .s_axis_tready(s_tready[0]), .s_axis_tlast(s_tlast[0]), .s_axis_tuser(s_tuser[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tvalid(m_vld[0]),
        .m_axis_tready(m_rdy[0]), .m_axis_tlast(m_tlast[0]), .m_axis_tuser(m_tuser[0]),
        .stat_rx_frames(st_frames[0]), .stat_rx_runt(st_runt[0]),
        .stat_rx_oversize(st_over[0]), .stat_rx_fcs_err(st_fcs[0])
    );

    kugelblitz_rx_frame_check #(.MAX_FRAME_LEN(128)) dut1 (
        .qsfp_rx_clk(clk), .qsfp_rx_rst_n(rst_n),
        .s_axis_tdata(s_tdata[1]), .s_axis_tkeep(s_tkeep[1]), .s_axis_tvalid(s_tvalid[1]),
        .s_axis_tready(s_tready[1]), .s_axis_tlast(s_tlast[1]), .s_axis_tuser(s_tuser[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tvalid(m_vld[1]),
        .m_axis_tready(m_rdy[1]), .m_axis_tlast(m_tlast[1]), .m_axis_tuser(m_tuser[1]),
        .stat_rx_frames(st_frames[1]), .stat_rx_runt(st_runt[1]),
        .stat_rx_oversize(st_over[1]), .stat_rx_fcs_err(st_fcs[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int max_len(input int inst);
        return (inst == 0) ? 9600 : 128;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] keep_of(input int n);
        logic [63:0] k;
        k = '0;
        for (int i = 0; i < n; i++) k[i] = 1'b1;
        return k;
    endfunction

    function automatic logic [511:0] zero_tail(input logic [511:0] d, input int n);
        logic [511:0] r;
        r = d;
        for (int i = n; i < 64; i++) r[i*8 +: 8] = 8'h00;
        return r;
    endfunction

    task automatic push_exp(input int inst, input logic [511:0] d, input logic [63:0] k,
                            input logic l, input logic u);
        beat_t b;
        b.d = d; b.k = k; b.l = l; b.u = u;
        if (inst == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    // Ready pattern: 0 = always ready, 1 = random, 2 = toggle every cycle.
    initial begin
        m_rdy[0] = 1'b1;
        m_rdy[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                case (rdy_mode)
                    1:       m_rdy[i] = ($urandom_range(0, 3) != 0);
                    2:       m_rdy[i] = ~m_rdy[i];
                    default: m_rdy[i] = 1'b1;
                endcase
            end
        end
    end

    task automatic send_beat(input int inst, input logic [511:0] d, input logic [63:0] k,
                             input logic l, input logic u);
        bit acc;
        s_tdata[inst]  = d;
        s_tkeep[inst]  = k;
        s_tlast[inst]  = l;
        s_tuser[inst]  = u;
        s_tvalid[inst] = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            acc = s_tready[inst];
            @(posedge clk);
            #1;
        end
        s_tvalid[inst] = 1'b0;
        chk($sformatf("accept_timeout%0d", inst), 512'(acc), 512'(1));
    endtask

    // Frame-level model: runts vanish, bytes past the limit truncate the frame on that beat.
    task automatic send_frame(input int inst, input int nbeats, input int last_bytes,
                              input bit err, input bit gaps);
        int           cum;
        int           nb;
        bit           cut;
        bit           runt;
        bit           last;
        logic [511:0] d;
        cum  = 0;
        cut  = 1'b0;
        runt = (nbeats == 1) && (last_bytes < MIN_LEN);
        if (runt) m_runt[inst]++;
        for (int b = 0; b < nbeats; b++) begin
            last = (b == nbeats - 1);
            nb   = last ? last_bytes : 64;
            d    = rand512();
            if (!runt && !cut) begin
                cum += nb;
                if (cum > max_len(inst)) begin
                    push_exp(inst, zero_tail(d, nb), keep_of(nb), 1'b1, 1'b1);
                    m_over[inst]++;
                    m_frames[inst]++;
                    cut = 1'b1;
                end else begin
                    push_exp(inst, zero_tail(d, nb), keep_of(nb), last, last & err);
                    if (last) begin
                        m_frames[inst]++;
                        if (err) m_fcs[inst]++;
                    end
                end
            end
            send_beat(inst, d, keep_of(nb), last, last & err);
            if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
            if (gaps) #1;
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 2000 && (q0.size() != 0 || q1.size() != 0); c++) @(posedge clk);
        chk("drain", 512'(q0.size() + q1.size()), 512'(0));
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_frames%0d", tag, i), 512'(st_frames[i]), 512'(STATS_EN ? m_frames[i] : 0));
            chk($sformatf("%s_runt%0d", tag, i), 512'(st_runt[i]), 512'(STATS_EN ? m_runt[i] : 0));
            chk($sformatf("%s_over%0d", tag, i), 512'(st_over[i]), 512'(STATS_EN ? m_over[i] : 0));
            chk($sformatf("%s_fcs%0d", tag, i), 512'(st_fcs[i]), 512'(STATS_EN ? m_fcs[i] : 0));
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n !== 1'b1) begin
                hold_v[i] = 1'b0;
            end else begin
                if (hold_v[i]) begin
                    chk($sformatf("hold_vld%0d", i), 512'(m_vld[i]), 512'(1));
                    chk($sformatf("hold_data%0d", i), m_tdata[i], hold_d[i]);
                    chk($sformatf("hold_ctl%0d", i), 512'({m_tkeep[i], m_tlast[i], m_tuser[i]}),
                        512'(hold_c[i]));
                end
                if (m_vld[i] === 1'b1 && m_rdy[i]) begin
                    if (i == 0) chk("unexpected_beat0", 512'(q0.size() != 0), 512'(1));
                    else        chk("unexpected_beat1", 512'(q1.size() != 0), 512'(1));
                    if ((i == 0 && q0.size() != 0) || (i == 1 && q1.size() != 0)) begin
                        e_tmp = (i == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("beat_data%0d", i), m_tdata[i], e_tmp.d);
                        chk($sformatf("beat_keep%0d", i), 512'(m_tkeep[i]), 512'(e_tmp.k));
                        chk($sformatf("beat_last%0d", i), 512'(m_tlast[i]), 512'(e_tmp.l));
                        chk($sformatf("beat_user%0d", i), 512'(m_tuser[i]), 512'(e_tmp.u));
                    end
                end
                hold_v[i] = (m_vld[i] === 1'b1) && !m_rdy[i];
                hold_d[i] = m_tdata[i];
                hold_c[i] = {m_tkeep[i], m_tlast[i], m_tuser[i]};
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 2; i++) begin
            s_tvalid[i] = 1'b0; s_tdata[i] = '0; s_tkeep[i] = '0;
            s_tlast[i]  = 1'b0; s_tuser[i] = '0;
            m_frames[i] = 0; m_runt[i] = 0; m_over[i] = 0; m_fcs[i] = 0;
            hold_v[i]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_vld%0d", i), 512'(m_vld[i]), 512'(0));
            chk($sformatf("reset_data%0d", i), m_tdata[i], 512'(0));
            chk($sformatf("reset_ctl%0d", i), 512'({m_tkeep[i], m_tlast[i], m_tuser[i]}), 512'(0));
            chk($sformatf("reset_rdy%0d", i), 512'(s_tready[i]), 512'(1));
        end
        check_stats("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 60-byte single beat with junk past the valid bytes
        send_frame(0, 1, 60, 1'b0, 1'b0);
        chk("f60_latency_vld", 512'(m_vld[0]), 512'(1));
        chk("f60_tail_zero", 512'(m_tdata[0][511:480]), 512'(0));
        wait_drain();
        check_stats("f60");

        // 40-byte runt, and a runt carrying an FCS error
        send_frame(0, 1, 40, 1'b0, 1'b0);
        chk("runt_no_vld", 512'(m_vld[0]), 512'(0));
        send_frame(1, 1, 10, 1'b1, 1'b0);
        wait_drain();
        check_stats("runt");

        // 150-byte frame under toggling ready
        rdy_mode = 2;
        send_frame(0, 3, 22, 1'b0, 1'b0);
        wait_drain();
        check_stats("toggle");
        rdy_mode = 0;

        // 256-byte frame into the 128-byte limit, then a clean 64-byte frame
        send_frame(1, 4, 64, 1'b0, 1'b0);
        send_frame(1, 1, 64, 1'b0, 1'b0);
        wait_drain();
        check_stats("oversize");

        // FCS error on a 128-byte frame; and FCS error on a frame that also goes oversize
        send_frame(0, 2, 64, 1'b1, 1'b0);
        send_frame(1, 3, 64, 1'b1, 1'b0);
        send_frame(1, 2, 64, 1'b1, 1'b0);
        wait_drain();
        check_stats("fcs");

        // reset while beat 2 of a 3-beat frame is offered
        push_exp(0, zero_tail(64'hFFFF_FFFF_FFFF_FFFF, 64), '1, 1'b0, 1'b0);
        send_beat(0, 512'(64'hFFFF_FFFF_FFFF_FFFF), '1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        s_tdata[0]  = rand512();
        s_tkeep[0]  = '1;
        s_tlast[0]  = 1'b0;
        s_tvalid[0] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_vld", 512'(m_vld[0]), 512'(0));
        chk("midrst_data", m_tdata[0], 512'(0));
        chk("midrst_pending", 512'(q0.size()), 512'(0));
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            m_frames[i] = 0; m_runt[i] = 0; m_over[i] = 0; m_fcs[i] = 0;
        end
        check_stats("midrst");
        s_tvalid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(0, 2, 30, 1'b0, 1'b0);
        wait_drain();
        check_stats("post_rst");

        // random frames with random backpressure and input gaps on both instances
        rdy_mode = 1;
        for (int f = 0; f < 80; f++) begin
            send_frame(f % 2, $urandom_range(1, 5), $urandom_range(1, 64),
                       ($urandom_range(0, 3) == 0), 1'b1);
        end
        wait_drain();
        check_stats("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
